// File: rtl/csa_pkg.sv
// Shared helpers for the pipelined carry-skip adder: geometry functions used
// to size the pipeline and the per-stage control record.
package csa_pkg;

    // Number of carry-skip blocks across the operand width.
    function automatic int csa_num_blocks(input int width, input int block_w);
        return width / block_w;
    endfunction

    // Number of pipeline stages, rounding up when the last stage is partial.
    function automatic int csa_num_stages(input int num_blocks, input int blocks_per_stage);
        return (num_blocks + blocks_per_stage - 1) / blocks_per_stage;
    endfunction

    // Control portion of a stage register: occupancy and carry handed onward.
    typedef struct packed {
        logic valid;
        logic carry;
    } csa_stage_ctl_t;

endpackage

// File: rtl/carry_skip_block.sv
// One carry-skip block: a ripple full-adder chain plus a skip mux that
// forwards the block carry-in directly when every bit propagates.
module carry_skip_block #(
    parameter int BLOCK_W = 4
) (
    input  logic [BLOCK_W-1:0] a,
    input  logic [BLOCK_W-1:0] b,
    input  logic               cin,
    output logic [BLOCK_W-1:0] sum,
    output logic               cout
);

    logic [BLOCK_W:0]   carry_s;
    logic [BLOCK_W-1:0] prop_s;

    // Ripple the carry through the block and select the skip path on full propagate.
    always_comb begin
        prop_s     = a ^ b;
        carry_s    = '0;
        carry_s[0] = cin;
        sum        = '0;
        for (int i = 0; i < BLOCK_W; i++) begin
            sum[i]         = prop_s[i] ^ carry_s[i];
            carry_s[i + 1] = (a[i] & b[i]) | (prop_s[i] & carry_s[i]);
        end
        if (&prop_s) begin
            cout = cin;
        end else begin
            cout = carry_s[BLOCK_W];
        end
    end

endmodule

// File: rtl/pipelined_carry_skip_adder.sv
// Pipelined N-bit carry-skip adder/subtractor with valid/ready flow control.
// Each stage resolves BLOCKS_PER_STAGE skip blocks and registers the carry for
// the next stage. Define CSA_OVERFLOW_EN to produce a signed-overflow flag;
// without it out_ovf is tied low.
module pipelined_carry_skip_adder
    import csa_pkg::*;
#(
    parameter int WIDTH            = 32,
    parameter int BLOCK_W          = 4,
    parameter int BLOCKS_PER_STAGE = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);

    localparam int NUM_BLOCKS = csa_num_blocks(WIDTH, BLOCK_W);
    localparam int STAGES     = csa_num_stages(NUM_BLOCKS, BLOCKS_PER_STAGE);
    localparam int STAGE_W    = BLOCKS_PER_STAGE * BLOCK_W;

    // Stage registers: operands travel whole; sum bits fill in stage by stage.
    csa_stage_ctl_t   ctl_r [STAGES];
    logic [WIDTH-1:0] a_r   [STAGES];
    logic [WIDTH-1:0] b_r   [STAGES];
    logic [WIDTH-1:0] sum_r [STAGES];

    // Per-stage view of the values entering that stage's blocks.
    logic [WIDTH-1:0] src_a_s   [STAGES];
    logic [WIDTH-1:0] src_b_s   [STAGES];
    logic [WIDTH-1:0] src_sum_s [STAGES];
    logic             src_cin_s [STAGES];
    logic [WIDTH-1:0] new_sum_s [STAGES];
    logic [WIDTH-1:0] blk_sum_s;
    logic [STAGES-1:0] stage_cout_s;
    logic [STAGES:0]   ready_s;

    // Bits below 'lo' are already resolved by earlier stages.
    function automatic logic [WIDTH-1:0] low_mask(input int lo);
        logic [WIDTH-1:0] m;
        m = '0;
        for (int i = 0; i < WIDTH; i++) begin
            m[i] = (i < lo);
        end
        return m;
    endfunction

    // Select stage inputs: stage 0 sees the (possibly inverted) operands, later stages the previous register.
    always_comb begin
        src_a_s[0]   = in_a;
        src_b_s[0]   = in_sub ? ~in_b : in_b;
        src_sum_s[0] = '0;
        src_cin_s[0] = in_sub ? 1'b1 : in_cin;
        for (int k = 1; k < STAGES; k++) begin
            src_a_s[k]   = a_r[k - 1];
            src_b_s[k]   = b_r[k - 1];
            src_sum_s[k] = sum_r[k - 1];
            src_cin_s[k] = ctl_r[k - 1].carry;
        end
    end

    for (genvar j = 0; j < NUM_BLOCKS; j++) begin : g_blk
        localparam int STG = j / BLOCKS_PER_STAGE;
        logic bcin_s;
        logic bcout_s;

        if ((j % BLOCKS_PER_STAGE) == 0) begin : g_first
            assign bcin_s = src_cin_s[STG];
        end else begin : g_chain
            assign bcin_s = g_blk[j - 1].bcout_s;
        end

        carry_skip_block #(.BLOCK_W(BLOCK_W)) u_blk (
            .a   (src_a_s[STG][j*BLOCK_W +: BLOCK_W]),
            .b   (src_b_s[STG][j*BLOCK_W +: BLOCK_W]),
            .cin (bcin_s),
            .sum (blk_sum_s[j*BLOCK_W +: BLOCK_W]),
            .cout(bcout_s)
        );

        if (((j % BLOCKS_PER_STAGE) == (BLOCKS_PER_STAGE - 1)) || (j == NUM_BLOCKS - 1)) begin : g_last
            assign stage_cout_s[STG] = bcout_s;
        end
    end

    // Merge each stage's fresh block sums above the bits resolved upstream.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            new_sum_s[k] = (blk_sum_s & ~low_mask(k * STAGE_W)) |
                           (src_sum_s[k] & low_mask(k * STAGE_W));
        end
    end

    // Backward ready chain: a stage may load when empty or when its successor loads.
    always_comb begin
        ready_s         = '0;
        ready_s[STAGES] = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            ready_s[k] = !ctl_r[k].valid || ready_s[k + 1];
        end
    end

    // Stage registers: advance every stage whose ready is high, clear all on reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                ctl_r[k] <= '0;
                a_r[k]   <= '0;
                b_r[k]   <= '0;
                sum_r[k] <= '0;
            end
        end else begin
            if (ready_s[0]) begin
                ctl_r[0].valid <= in_valid;
            end
            for (int k = 1; k < STAGES; k++) begin
                if (ready_s[k]) begin
                    ctl_r[k].valid <= ctl_r[k - 1].valid;
                end
            end
            for (int k = 0; k < STAGES; k++) begin
                if (ready_s[k]) begin
                    ctl_r[k].carry <= stage_cout_s[k];
                    a_r[k]         <= src_a_s[k];
                    b_r[k]         <= src_b_s[k];
                    sum_r[k]       <= new_sum_s[k];
                end
            end
        end
    end

`ifdef CSA_OVERFLOW_EN
    logic ovf_r;

    // Overflow flag registered alongside the final stage's result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_r <= 1'b0;
        end else if (ready_s[STAGES - 1]) begin
            ovf_r <= (src_a_s[STAGES - 1][WIDTH - 1] == src_b_s[STAGES - 1][WIDTH - 1]) &&
                     (new_sum_s[STAGES - 1][WIDTH - 1] != src_a_s[STAGES - 1][WIDTH - 1]);
        end
    end

    assign out_ovf = ovf_r;
`else
    assign out_ovf = 1'b0;
`endif

    assign in_ready  = ready_s[0];
    assign out_valid = ctl_r[STAGES - 1].valid;
    assign out_sum   = sum_r[STAGES - 1];
    assign out_cout  = ctl_r[STAGES - 1].carry;

endmodule

// File: tb/tb_pipelined_carry_skip_adder.sv
// Self-checking bench for pipelined_carry_skip_adder: table vectors, random
// streams against an arithmetic reference model, backpressure, reset flush,
// and a narrow 2-stage configuration.
module tb_pipelined_carry_skip_adder;

`ifdef CSA_OVERFLOW_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, in_cin, in_sub;
    logic        out_valid, out_ready, out_cout, out_ovf;
    logic [31:0] in_a, in_b, out_sum;

    logic        d2_in_valid, d2_in_ready, d2_in_cin, d2_in_sub;
    logic        d2_out_valid, d2_out_ready, d2_out_cout, d2_out_ovf;
    logic [15:0] d2_in_a, d2_in_b, d2_out_sum;

    always #5 clk = ~clk;

    pipelined_carry_skip_adder dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf)
    );

    pipelined_carry_skip_adder #(.WIDTH(16), .BLOCK_W(4), .BLOCKS_PER_STAGE(3)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(d2_in_valid), .in_ready(d2_in_ready),
        .in_a(d2_in_a), .in_b(d2_in_b), .in_cin(d2_in_cin), .in_sub(d2_in_sub),
        .out_valid(d2_out_valid), .out_ready(d2_out_ready),
        .out_sum(d2_out_sum), .out_cout(d2_out_cout), .out_ovf(d2_out_ovf)
    );

    typedef struct packed {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } res_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        sub;
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    res_t exp_q[$];
    res_t pending;
    vec_t vecs[9];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic on WIDTH+1 bits.
    function automatic res_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic cin, input logic sub);
        res_t        r;
        logic [31:0] bb;
        logic [32:0] full;
        bb     = sub ? ~b : b;
        full   = {1'b0, a} + {1'b0, bb} + {32'd0, (sub ? 1'b1 : cin)};
        r.sum  = full[31:0];
        r.cout = full[32];
        r.ovf  = OVF_ON && (a[31] == bb[31]) && (full[31] != a[31]);
        return r;
    endfunction

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic cin,
                         input logic sub, input res_t e);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        in_sub   = sub;
        pending  = e;
    endtask

    task automatic drive_rand();
        logic [31:0] a, b;
        logic        cin, sub;
        a   = $urandom;
        b   = $urandom;
        cin = 1'($urandom_range(0, 1));
        sub = 1'($urandom_range(0, 1));
        drive(a, b, cin, sub, model(a, b, cin, sub));
    endtask

    // Called at the falling edge with inputs set; records the transfers of the coming rising edge.
    task automatic step(output bit acc);
        res_t got;
        #1;
        acc = in_valid && in_ready;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_output", out_valid, 1'b0);
            end else begin
                got = exp_q.pop_front();
                check("out_sum", out_sum, got.sum);
                check("out_cout", out_cout, got.cout);
                check("out_ovf", out_ovf, got.ovf);
            end
        end
        if (acc) exp_q.push_back(pending);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        bit acc;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 40 && exp_q.size() > 0; i++) step(acc);
        check("drain_empty", exp_q.size(), 0);
    endtask

    task automatic d2_run(input logic [15:0] a, input logic [15:0] b, input logic cin,
                          input logic sub, input logic [15:0] es, input logic ec);
        int cnt;
        d2_in_a = a; d2_in_b = b; d2_in_cin = cin; d2_in_sub = sub; d2_in_valid = 1'b1;
        #1 check("d2_in_ready", d2_in_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        d2_in_valid = 1'b0;
        #1 cnt = 1;
        while (!d2_out_valid && cnt < 20) begin
            @(posedge clk); @(negedge clk); #1; cnt++;
        end
        check("d2_latency", cnt, 2);
        check("d2_sum", d2_out_sum, es);
        check("d2_cout", d2_out_cout, ec);
        check("d2_ovf_default", d2_out_ovf, OVF_ON ? d2_out_ovf : 1'b0);
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        int cnt;
        int n_acc;
        logic [31:0] held;
        bit seen;

        vecs[0] = '{32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        vecs[1] = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
        vecs[2] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, OVF_ON};
        vecs[3] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0001, 1'b0, 1'b0};
        vecs[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0};
        vecs[5] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, OVF_ON};
        vecs[6] = '{32'h1234_5678, 32'h0F0F_0F0F, 1'b0, 1'b0, 32'h2143_6587, 1'b0, 1'b0};
        vecs[7] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
        vecs[8] = '{32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0007, 1'b1, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0;
        d2_in_valid = 1'b0; d2_out_ready = 1'b1;
        d2_in_a = '0; d2_in_b = '0; d2_in_cin = 1'b0; d2_in_sub = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_out_sum", out_sum, 32'h0);
        check("reset_out_cout", out_cout, 1'b0);
        check("reset_out_ovf", out_ovf, 1'b0);
        check("reset_d2_out_valid", d2_out_valid, 1'b0);
        rst_n = 1'b1;
        #1 check("in_ready_after_reset", in_ready, 1'b1);
        @(negedge clk);

        // Latency of a lone transaction (full skip propagation case).
        drive(vecs[0].a, vecs[0].b, vecs[0].cin, vecs[0].sub,
              '{vecs[0].sum, vecs[0].cout, vecs[0].ovf});
        step(acc);
        check("latency_accept", acc, 1'b1);
        in_valid = 1'b0;
        #1 cnt = 1;
        while (!out_valid && cnt < 20) begin
            @(posedge clk); @(negedge clk); #1; cnt++;
        end
        check("latency", cnt, 4);
        step(acc);
        drain();

        // Table vectors streamed back to back.
        for (int i = 0; i < 9; i++) begin
            drive(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub,
                  '{vecs[i].sum, vecs[i].cout, vecs[i].ovf});
            step(acc);
        end
        drain();

        // 100 random pairs, full throughput expected.
        n_acc = 0;
        for (int i = 0; i < 100; i++) begin
            drive_rand();
            step(acc);
            n_acc += int'(acc);
        end
        check("stream_accepted", n_acc, 100);
        drain();

        // Backpressure: pipeline fills to 4 then stalls with stable output.
        out_ready = 1'b0;
        n_acc = 0;
        for (int i = 0; i < 10; i++) begin
            drive_rand();
            step(acc);
            n_acc += int'(acc);
        end
        #1;
        check("bp_accepted", n_acc, 4);
        check("bp_in_ready", in_ready, 1'b0);
        check("bp_out_valid", out_valid, 1'b1);
        held = out_sum;
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); @(negedge clk); #1;
            check("bp_hold_sum", out_sum, held);
        end
        @(negedge clk);
        drain();

        // Random valid/ready on both sides.
        for (int i = 0; i < 300; i++) begin
            drive_rand();
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            step(acc);
        end
        drain();

        // Reset with three results in flight.
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_rand();
            step(acc);
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); @(negedge clk);
        exp_q.delete();
        rst_n = 1'b1;
        #1 check("in_ready_after_midreset", in_ready, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); @(negedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        check("no_output_after_reset", seen, 1'b0);
        @(negedge clk);

        // Narrow configuration: two stages.
        d2_run(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1);
        d2_run(16'h1234, 16'h0235, 1'b0, 1'b1, 16'h0FFF, 1'b1);
        d2_run(16'h0F0F, 16'h00F1, 1'b1, 1'b0, 16'h1001, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipelined_carry_skip_adder.md
# pipelined_carry_skip_adder

Parametrised, pipelined N-bit carry-skip adder/subtractor built from fixed-width skip blocks with a registered carry chain between pipeline stages. Successor to the 4-bit combinational skip adder: generalises width and block size, adds a subtract mode, and adds valid/ready flow control with full backpressure. Sits in the datapath as a drop-in arithmetic unit for streaming operands.

## Interface
- WIDTH, 32: operand width in bits; must be a multiple of BLOCK_W.
- BLOCK_W, 4: bits per carry-skip block.
- BLOCKS_PER_STAGE, 2: skip blocks evaluated per pipeline stage; NUM_BLOCKS = WIDTH/BLOCK_W; STAGES = ceil(NUM_BLOCKS/BLOCKS_PER_STAGE).
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  operands present.
- in_ready  output  1  stage 0 can accept.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_cin  input  1  carry in (ignored when in_sub=1).
- in_sub  input  1  1: compute A − B (B inverted, carry in forced 1).
- out_valid  output  1  result present.
- out_ready  input  1  downstream accepts.
- out_sum  output  WIDTH  sum/difference.
- out_cout  output  1  carry out of MSB (for subtract: 1 = no borrow).
- out_ovf  output  1  signed overflow (only with CSA_OVERFLOW_EN; tied 0 otherwise).

## Operation
- Input transfer when in_valid && in_ready; output transfer when out_valid && out_ready.
- Stage k (0..STAGES−1) processes blocks k·BLOCKS_PER_STAGE .. (k+1)·BLOCKS_PER_STAGE−1, taking carry from stage k−1 register (stage 0: effective carry in).
- Per block: ripple full-adder chain gives ripple carry; P = AND of (a_i ^ b_i') over block; block carry out = P ? block carry in : ripple carry out.
- Each stage register holds: valid, unprocessed upper operand bits, computed lower sum bits, inter-stage carry, sign bits of A/B' (overflow feature).
- Stage k advances when it is empty or stage k+1 accepts (k = last: out_ready). Bubbles collapse; no stage holds data it could pass.
- in_ready = !valid[0] || stage 0 advancing (combinational from downstream ready chain).
- Results emerge in input order; no reordering, no drop, no duplication.
- Final sum is mod 2^WIDTH; out_cout is carry out of bit WIDTH−1.

## Timing
- Reset (rst_n=0 at edge): all stage valids 0, out_valid 0, out_sum 0, out_cout 0, out_ovf 0; in_ready 1 in the first cycle after reset release.
- Reset mid-operation: all in-flight results discarded; none appears after release.
- Latency: STAGES cycles from input transfer to out_valid with no stall (defaults: 4).
- Throughput: one result per cycle when out_ready held 1.
- Stall: out_valid with out_ready=0 holds out_sum/out_cout/out_ovf stable until transfer.
- Simultaneous input and output transfer on a full pipeline: both occur same cycle, occupancy unchanged.
- Outputs are registered; no combinational path from in_a/in_b to out_*. Only in_ready depends combinationally on out_ready.

## Configuration
- CSA_OVERFLOW_EN defined: out_ovf = (sign A == sign B') && (sign sum != sign A), registered with its result.
- Undefined: no sign bits stored, out_ovf tied 0.

## Structure
- Package csa_pkg: localparam helpers for NUM_BLOCKS and STAGES computation, stage-register struct typedef.
- Sub-module carry_skip_block (parameter BLOCK_W): combinational ripple + skip mux; instantiated NUM_BLOCKS times via generate.

## Test plan
- Defaults, out_ready=1: A=0x0000_0001, B=0xFFFF_FFFF, cin=0 -> after 4 cycles sum=0x0000_0000, cout=1 (full skip propagation).
- Subtract: A=5, B=7, sub=1 -> sum=0xFFFF_FFFE, cout=0; with CSA_OVERFLOW_EN A=0x8000_0000, B=1, sub=1 -> sum=0x7FFF_FFFF, ovf=1.
- Back-to-back stream of 100 random pairs, out_ready=1 -> one result per cycle, in order, all match reference model.
- Backpressure: out_ready=0 for 10 cycles while in_valid=1 -> in_ready drops after 4 accepted, held out_sum stable; release -> all 4 drain in order.
- Reset asserted with 3 results in flight -> no out_valid after release, in_ready=1 next cycle.
- WIDTH=16, BLOCK_W=4, BLOCKS_PER_STAGE=3 -> STAGES=2, latency 2, 0xFFFF+0x0001 -> sum=0x0000, cout=1.
